// File: rtl/csa_mp_add_seq_if.sv
// Handshake bundle for the multi-precision add sequencer: operand side and result side.
// Latency: none (wires only).
// Backpressure: in_ready/out_ready carry the valid-ready flow control in each direction.
// Ports: in_valid/in_ready/op_a/op_b/c_in (operand channel), out_valid/out_ready/result/c_out
// (result channel), busy (status). With CSA_SEQ_SUB_EN defined, adds `sub` to the operand channel.
interface csa_mp_add_seq_if #(
    parameter int WORDS = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [16*WORDS-1:0]    op_a;
    logic [16*WORDS-1:0]    op_b;
    logic                   c_in;
`ifdef CSA_SEQ_SUB_EN
    logic                   sub;
`endif
    logic                   out_valid;
    logic                   out_ready;
    logic [16*WORDS-1:0]    result;
    logic                   c_out;
    logic                   busy;

    // Producer/consumer side (drives operands, accepts results).
    modport master (
`ifdef CSA_SEQ_SUB_EN
        output sub,
`endif
        output in_valid, op_a, op_b, c_in, out_ready,
        input  in_ready, out_valid, result, c_out, busy
    );

    // Sequencer side.
    modport slave (
`ifdef CSA_SEQ_SUB_EN
        input  sub,
`endif
        input  in_valid, op_a, op_b, c_in, out_ready,
        output in_ready, out_valid, result, c_out, busy
    );
endinterface

// File: rtl/csa_mp_add_seq.sv
// Multi-precision adder: one 16-bit carry-select adder walked LS word first, carry chained across words.
// Latency: out_valid rises WORDS cycles after the accept edge; result held until out handshake.
// Backpressure: in_ready only in IDLE; result held indefinitely while out_ready=0, no same-cycle re-accept.
// Ports: clk, rst_n (synchronous, active-low), bus (csa_mp_add_seq_if.slave: operand and result channels, busy).
// Optional macro CSA_SEQ_SUB_EN: adds bus.sub; sub=1 stores ~op_b and forces the initial carry to 1,
// giving op_a - op_b with c_out=1 meaning no borrow.
module csa_mp_add_seq #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    csa_mp_add_seq_if.slave     bus
);
    localparam int W  = 16 * WORDS;
    localparam int IW = $clog2(WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic [W-1:0]   result_q;
    logic           carry;
    logic           c_out_q;
    logic [IW-1:0]  idx;
    logic           last_word;

    // Single CSA: low byte ripples, high byte is precomputed for both carry-ins and selected.
    logic [15:0]    csa_a;
    logic [15:0]    csa_b;
    logic [15:0]    csa_sum;
    logic           csa_co;
    logic [8:0]     lo;
    logic [8:0]     hi0;
    logic [8:0]     hi1;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.result    = result_q;
    assign bus.c_out     = c_out_q;

    assign last_word = (idx == IW'(WORDS - 1));

    always_comb begin
        csa_a   = a_reg[{idx, 4'h0} +: 16];
        csa_b   = b_reg[{idx, 4'h0} +: 16];
        lo      = {1'b0, csa_a[7:0]}  + {1'b0, csa_b[7:0]}  + {8'h00, carry};
        hi0     = {1'b0, csa_a[15:8]} + {1'b0, csa_b[15:8]};
        hi1     = {1'b0, csa_a[15:8]} + {1'b0, csa_b[15:8]} + 9'd1;
        csa_sum = lo[8] ? {hi1[7:0], lo[7:0]} : {hi0[7:0], lo[7:0]};
        csa_co  = lo[8] ? hi1[8] : hi0[8];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = RUN;
            RUN:     if (last_word)     state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            result_q <= '0;
            carry    <= 1'b0;
            c_out_q  <= 1'b0;
            idx      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg <= bus.op_a;
                        idx   <= '0;
`ifdef CSA_SEQ_SUB_EN
                        // Two's-complement subtract: invert B and inject the +1 as the initial carry.
                        b_reg <= bus.sub ? ~bus.op_b : bus.op_b;
                        carry <= bus.sub ? 1'b1 : bus.c_in;
`else
                        b_reg <= bus.op_b;
                        carry <= bus.c_in;
`endif
                    end
                end
                RUN: begin
                    result_q[{idx, 4'h0} +: 16] <= csa_sum;
                    carry <= csa_co;
                    idx   <= idx + IW'(1);
                    if (last_word) begin
                        c_out_q <= csa_co;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_csa_mp_add_seq.sv
// Testbench for csa_mp_add_seq (WORDS=4): directed corner cases plus randomized operands,
// checked every cycle against a plain-arithmetic reference model.
// Summary line reports comparisons made and failures.
module tb_csa_mp_add_seq;
    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    csa_mp_add_seq_if #(.WORDS(WORDS)) bus();

    csa_mp_add_seq #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: {c_out,result} as a (16*WORDS+1)-bit integer sum.
    function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic ci, input logic sb);
        logic [W:0] r;
        if (sb) r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        else    r = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
        return r;
    endfunction

    // ---------------- Behavioural model + per-cycle compare ----------------
    // Model state describes what should be visible after the most recent rising edge.
    logic       drv_sub = 1'b0;
    bit         model_ok = 1'b0;
    bit         pending  = 1'b0;
    int         cnt      = 0;
    logic [W:0] exp_v    = '0;
    logic [W:0] last_v   = '0;

    always @(negedge clk) begin
        if (model_ok) begin
            if (!pending) begin
                chk("idle_in_ready",  bus.in_ready,  1);
                chk("idle_out_valid", bus.out_valid, 0);
                chk("idle_busy",      bus.busy,      0);
                chk("idle_result",    {bus.c_out, bus.result}, last_v);
            end else if (cnt > 0) begin
                chk("run_in_ready",  bus.in_ready,  0);
                chk("run_out_valid", bus.out_valid, 0);
                chk("run_busy",      bus.busy,      1);
            end else begin
                chk("done_in_ready",  bus.in_ready,  0);
                chk("done_out_valid", bus.out_valid, 1);
                chk("done_busy",      bus.busy,      1);
                chk("done_result",    {bus.c_out, bus.result}, exp_v);
            end
        end
        // Advance the model across the coming rising edge.
        if (!rst_n) begin
            pending  = 1'b0;
            last_v   = '0;
            model_ok = 1'b1;
        end else if (!pending) begin
            if (bus.in_valid) begin
                pending = 1'b1;
                cnt     = WORDS;
                exp_v   = ref_sum(bus.op_a, bus.op_b, bus.c_in, drv_sub);
            end
        end else if (cnt > 0) begin
            cnt--;
        end else if (bus.out_ready) begin
            pending = 1'b0;
            last_v  = exp_v;
        end
    end

    // ---------------- Stimulus ----------------
    task automatic scramble_inputs();
        bus.op_a = {$urandom, $urandom};
        bus.op_b = {$urandom, $urandom};
        bus.c_in = 1'($urandom);
`ifdef CSA_SEQ_SUB_EN
        bus.sub  = 1'($urandom);
`endif
    endtask

    task automatic present(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic ci, input logic sb);
        int k;
        @(posedge clk);
        #1;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.c_in     = ci;
        drv_sub      = sb;
`ifdef CSA_SEQ_SUB_EN
        bus.sub      = sb;
`endif
        bus.in_valid = 1'b1;
        k = 0;
        while (!bus.in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!bus.in_ready) chk("accept_timeout", 0, 1);
        @(posedge clk);   // accept edge
        #1;
        bus.in_valid = 1'b0;
        scramble_inputs();  // registered operands must make later input changes irrelevant
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input logic sb, input bit lit, input logic [W:0] lit_v,
                          input int hold, input bit poke);
        int lat;
        present(a, b, ci, sb);
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            @(negedge clk);
            if (!bus.out_valid) lat++;
        end
        if (!bus.out_valid) chk("out_valid_timeout", 0, 1);
        if (lit) begin
            chk("latency",    lat, WORDS);
            chk("lit_result", {bus.c_out, bus.result}, lit_v);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid = (poke && i == 1);
            if (poke) scramble_inputs();
        end
        if (poke) begin
            @(negedge clk);
            chk("hold_in_ready",  bus.in_ready, 0);
            chk("hold_result",    {bus.c_out, bus.result}, lit_v);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);   // output handshake edge
        #1;
        bus.out_ready = 1'b0;
        if (lit) chk("post_hs_in_ready", bus.in_ready, 1);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rs;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.c_in      = 1'b0;
`ifdef CSA_SEQ_SUB_EN
        bus.sub       = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready",  bus.in_ready,  1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy",      bus.busy,      0);
        chk("rst_result",    bus.result,    0);
        chk("rst_c_out",     bus.c_out,     0);

        // Zero operands.
        run_op(64'h0, 64'h0, 1'b0, 1'b0, 1, 65'h0, 0, 0);
        // Carry ripples through every word.
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1,
               65'h1_0000_0000_0000_0000, 1, 0);
        // All ones plus carry-in.
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1,
               65'h1_FFFF_FFFF_FFFF_FFFF, 0, 0);
        // Five cycles of backpressure with an ignored in_valid pulse.
        run_op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1'b0, 1,
               65'h0_1234_5678_9ABC_DF00, 5, 1);

        // Reset while idx==2: operation aborted, outputs back to reset values.
        present(64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_busy",      bus.busy,      0);
        chk("midrst_in_ready",  bus.in_ready,  1);
        chk("midrst_result",    bus.result,    0);
        chk("midrst_c_out",     bus.c_out,     0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

`ifdef CSA_SEQ_SUB_EN
        run_op(64'd5, 64'd7, 1'b0, 1'b1, 1, 65'h0_FFFF_FFFF_FFFF_FFFE, 0, 0);
        run_op(64'd7, 64'd5, 1'b1, 1'b1, 1, 65'h1_0000_0000_0000_0002, 2, 0);
`endif

        // Randomized operands; some words forced to all-ones to stress carry chaining.
        for (int n = 0; n < 40; n++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            for (int w = 0; w < WORDS; w++) begin
                if ($urandom_range(0, 3) == 0) ra[w*16 +: 16] = 16'hFFFF;
                if ($urandom_range(0, 3) == 0) rb[w*16 +: 16] = 16'hFFFF ^ ra[w*16 +: 16];
            end
`ifdef CSA_SEQ_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            run_op(ra, rb, 1'($urandom), rs, 0, '0, $urandom_range(0, 3), 0);
        end

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
